// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a 64x8 dual-port RAM: port 1 writes pushes, port 2 reads pops.
// Popped data arrives on rd_data one cycle after the pop, qualified by rd_valid.
module ram_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int AFULL_TH = 56
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] ram_data1,
    output logic [ADDR_W-1:0] ram_adr1,
    output logic              ram_we1,
    output logic [DATA_W-1:0] ram_data2,
    output logic [ADDR_W-1:0] ram_adr2,
    output logic              ram_we2,
    input  logic [DATA_W-1:0] ram_q2
);
    localparam int PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_TH);

    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
    logic             rd_valid_reg, overflow_reg, underflow_reg;
    logic             overflow_next, underflow_next;
    logic             full_int, empty_int, push_ok, pop_ok;

    // Equal low bits with differing wrap bits means one full lap ahead.
    assign full_int  = (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]) &&
                       (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]);
    assign empty_int = (wr_ptr_reg == rd_ptr_reg);

    // Gated by rst_n so the RAM sees no write strobe while reset is held.
    assign push_ok = rst_n & wr_en & ~full_int;
    assign pop_ok  = rst_n & rd_en & ~empty_int;

    assign count       = wr_ptr_reg - rd_ptr_reg;
    assign full        = full_int;
    assign empty       = empty_int;
    assign almost_full = (count >= AFULL_LVL);
    assign overflow    = overflow_reg;
    assign underflow   = underflow_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_data     = ram_q2;

    assign ram_adr1  = wr_ptr_reg[ADDR_W-1:0];
    assign ram_data1 = wr_data;
    assign ram_we1   = push_ok;
    assign ram_adr2  = rd_ptr_reg[ADDR_W-1:0];
    assign ram_data2 = '0;
    assign ram_we2   = 1'b0;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg + {{ADDR_W{1'b0}}, push_ok};
        rd_ptr_next    = rd_ptr_reg + {{ADDR_W{1'b0}}, pop_ok};
        // A new rejection wins over a simultaneous clear.
        overflow_next  = (wr_en & full_int)  | (overflow_reg  & ~clr_flags);
        underflow_next = (rd_en & empty_int) | (underflow_reg & ~clr_flags);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rd_valid_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            rd_valid_reg  <= pop_ok;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end
endmodule
